cellrv32_wb_responder: RTL and testbench
========================================

CELLRV32_WB_RESPONDER -- requirements
Module: cellrv32_wb_responder

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, responder memory size in bytes (power of 2, >= 4).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h9000_0000, base address of the decoded window (aligned to MEM_SIZE).
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra wait cycles before response (0..15).
REQ-004 SHALL have parameter PIPE_MODE, default 1'b0, protocol (0 = classic, 1 = pipelined Wishbone).
REQ-005 SHALL have parameter PRIV_WR_ONLY, default 1'b0, reject unprivileged writes when 1.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 clk_i  in  1  global clock, rising edge.
REQ-008 rstn_i  in  1  global reset, asynchronous, active-low.
REQ-009 wb_tag_i  in  3  request tag ([0] privileged, [1] non-secure, [2] instruction access).
REQ-010 wb_adr_i  in  32  byte address.
REQ-011 wb_dat_i  in  32  write data.
REQ-012 wb_we_i  in  1  1 = write, 0 = read.
REQ-013 wb_sel_i  in  4  byte enables.
REQ-014 wb_stb_i  in  1  strobe.
REQ-015 wb_cyc_i  in  1  valid bus cycle.
REQ-016 wb_dat_o  out  32  read data, zero unless wb_ack_o is high on a read.
REQ-017 wb_ack_o  out  1  normal termination, single-cycle pulse.
REQ-018 wb_err_o  out  1  error termination, single-cycle pulse.
REQ-019 busy_o  out  1  high while a request is being processed (WAIT or RESP).

Function
REQ-020 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-021 Request accept: classic mode: IDLE and cyc&stb; pipelined mode: IDLE and cyc&stb (stb is a single-cycle pulse).
REQ-022 On accept, SHALL register adr, we, sel, dat and tag[0], load the wait counter with WAIT_STATES, and go to WAIT, or to RESP directly if WAIT_STATES=0.
REQ-023 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 0.
REQ-024 Latency: ack/err SHALL be asserted exactly WAIT_STATES+1 cycles after the accept cycle.
REQ-025 RESP SHALL last one cycle, assert exactly one of ack/err, then return to IDLE.
REQ-026 Decode: hit iff captured adr[31:log2(MEM_SIZE)] == BASE_ADDR[31:log2(MEM_SIZE)].
REQ-027 A miss, or PRIV_WR_ONLY=1 with a write and captured tag[0]=0, SHALL give err, with no memory update and wb_dat_o = 0.
REQ-028 A write hit SHALL update only the bytes selected by sel at word adr[log2(MEM_SIZE)-1:2], in the RESP cycle; sel=0 SHALL ack without change.
REQ-029 A read hit SHALL drive wb_dat_o with the addressed word in the ack cycle (synchronous memory read launched on entry to RESP), ignoring sel.
REQ-030 adr[1:0] SHALL be ignored; byte order SHALL be little-endian (sel[0] = dat[7:0]).
REQ-031 Abort: if cyc_i falls in WAIT or RESP, SHALL return to IDLE next cycle with no ack/err and no memory write.
REQ-032 Classic mode SHALL NOT accept a new request in the cycle after RESP (one IDLE cycle minimum); stb held high after ack SHALL NOT be re-accepted while cyc stays high and busy_o was high the previous cycle.
REQ-033 Requests arriving while busy SHALL be ignored (the initiator issues one outstanding access).
REQ-034 Memory contents are not reset and are undefined at power-up.

Reset
REQ-035 Reset SHALL force IDLE, counter 0, captured registers 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, busy_o=0, immediately and asynchronously.
REQ-036 Reset mid-transaction SHALL drop the response and leave memory unchanged for that access.

Structure
REQ-037 The FSM state enum and the wb tag bit indices SHALL live in cellrv32_package; parameters stay local.
REQ-038 Memory storage SHALL be one sub-module, cellrv32_wb_resp_ram (byte-enabled, synchronous read, one port).

Verification
REQ-039 WAIT_STATES=2, write 0xDEADBEEF to BASE_ADDR+0x10, sel=4'hF -> ack exactly 3 cycles after accept; a read of the same address returns 0xDEADBEEF with ack.
REQ-040 Write 0x000000AA with sel=4'b0001 over 0xDEADBEEF, then read -> 0xDEADBEAA.
REQ-041 Read from BASE_ADDR+MEM_SIZE -> wb_err_o pulse, wb_ack_o=0, wb_dat_o=0.
REQ-042 PRIV_WR_ONLY=1, write with tag=3'b000 -> err and word unchanged; write with tag=3'b001 -> ack and word updated.
REQ-043 WAIT_STATES=5, drop cyc during WAIT -> no ack/err, busy_o low next cycle, memory unchanged; the next request completes normally.
REQ-044 PIPE_MODE=1, back-to-back single-cycle stb reads after each ack -> one ack per request; assert rstn_i low in WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/cellrv32_package.sv
// Shared definitions for the cellrv32 Wishbone responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the responder FSM state encoding and the bit positions inside the
// 3-bit Wishbone request tag.
package cellrv32_package;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_WAIT = 2'd1,
        WB_RESP = 2'd2
    } wb_resp_state_t;

    // Wishbone request tag bit positions
    localparam int WB_TAG_PRIV  = 0;  // privileged access
    localparam int WB_TAG_NSEC  = 1;  // non-secure access
    localparam int WB_TAG_INSTR = 2;  // instruction fetch

endpackage

// File: rtl/cellrv32_wb_resp_ram.sv
// Single-port word memory with byte enables for the Wishbone responder.
// Latency: write lands on the clock edge; read data valid one cycle after rd_en.
// Backpressure: none, accepts one access per cycle (write and read never overlap).
//
// Ports:
//   clk_i   clock (rising edge)
//   wr_en   write strobe, byte_en selects the lanes written (little-endian)
//   rd_en   read strobe, rd_dat is registered and holds until the next read
//   addr    word index shared by read and write
// Contents are not reset.
module cellrv32_wb_resp_ram #(
    parameter int DEPTH = 256,
    parameter int IW    = 8
) (
    input  logic          clk_i,
    input  logic          wr_en,
    input  logic [3:0]    byte_en,
    input  logic [IW-1:0] addr,
    input  logic [31:0]   wr_dat,
    input  logic          rd_en,
    output logic [31:0]   rd_dat
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[addr][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_dat <= mem[addr];
        end
    end

endmodule

// File: rtl/cellrv32_wb_responder.sv
// Wishbone responder backed by a small local memory (classic or pipelined).
// Latency: ack/err exactly WAIT_STATES+1 cycles after the accept cycle, one-cycle pulse.
// Backpressure: one access outstanding; requests seen while busy are ignored.
//
// Ports:
//   clk_i, rstn_i       clock (rising edge), asynchronous active-low reset
//   wb_tag_i            request tag ([0] privileged, [1] non-secure, [2] instruction)
//   wb_adr_i/wb_dat_i   byte address / write data
//   wb_we_i/wb_sel_i    write enable / byte enables
//   wb_stb_i/wb_cyc_i   strobe / cycle valid
//   wb_dat_o            read data, zero except on a read ack
//   wb_ack_o/wb_err_o   normal / error termination
//   busy_o              high in WAIT and RESP
module cellrv32_wb_responder
    import cellrv32_package::*;
#(
    parameter int          MEM_SIZE     = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h9000_0000,
    parameter int          WAIT_STATES  = 1,
    parameter logic        PIPE_MODE    = 1'b0,
    parameter logic        PRIV_WR_ONLY = 1'b0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [2:0]  wb_tag_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        busy_o
);

    localparam int          AW    = $clog2(MEM_SIZE);
    localparam int          DEPTH = MEM_SIZE / 4;
    localparam int          IW    = (AW > 2) ? (AW - 2) : 1;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);
    localparam logic [31:0] AMASK = 32'(MEM_SIZE - 1);

    // Word index inside the memory window; the byte offset bits are dropped.
    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        return IW'((a & AMASK) >> 2);
    endfunction

    wb_resp_state_t state_q, state_n;
    logic [3:0]     cnt_q, cnt_n;
    logic           busy_q;
    logic           capture;

    logic [31:0]    adr_q;
    logic [31:0]    dat_q;
    logic [3:0]     sel_q;
    logic           we_q;
    logic           priv_q;

    logic           accept;
    logic           hit;
    logic           priv_rej;
    logic           fault;
    logic           resp_live;
    logic           ram_we;
    logic           ram_re;
    logic [IW-1:0]  ram_addr;
    logic [31:0]    ram_rdat;

    // Tag bits other than the privilege flag carry no meaning for this target.
    logic unused_tag;
    assign unused_tag = ^{wb_tag_i[WB_TAG_NSEC], wb_tag_i[WB_TAG_INSTR]};

    // Classic initiators may hold stb across the ack edge; blocking while the
    // previous cycle was busy forces one idle cycle so that stb is not taken
    // as a fresh request. Pipelined stb is a single-cycle pulse.
    assign accept = (state_q == WB_IDLE) && wb_cyc_i && wb_stb_i &&
                    (PIPE_MODE || !busy_q);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        capture = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    capture = 1'b1;
                    cnt_n   = WS;
                    state_n = (WAIT_STATES == 0) ? WB_RESP : WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (!wb_cyc_i) begin
                    state_n = WB_IDLE;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                    // counter hits zero on the same edge that enters RESP
                    if (cnt_q <= 4'd1) begin
                        state_n = WB_RESP;
                    end
                end
            end
            WB_RESP: begin
                state_n = WB_IDLE;
            end
            default: begin
                state_n = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= WB_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            priv_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            busy_q  <= busy_o;
            if (capture) begin
                adr_q  <= wb_adr_i;
                dat_q  <= wb_dat_i;
                sel_q  <= wb_sel_i;
                we_q   <= wb_we_i;
                priv_q <= wb_tag_i[WB_TAG_PRIV];
            end
        end
    end

    assign busy_o = (state_q != WB_IDLE);

    assign hit      = ((adr_q >> AW) == (BASE_ADDR >> AW));
    assign priv_rej = PRIV_WR_ONLY && we_q && !priv_q;
    assign fault    = !hit || priv_rej;

    // Dropping cyc in RESP cancels the response and the memory write.
    assign resp_live = (state_q == WB_RESP) && wb_cyc_i;

    assign wb_ack_o = resp_live && !fault;
    assign wb_err_o = resp_live && fault;
    assign wb_dat_o = (wb_ack_o && !we_q) ? ram_rdat : 32'd0;

    // Read is launched on the edge that enters RESP. With zero wait states
    // that edge is the accept edge, so the address comes straight off the bus.
    assign ram_re   = (state_n == WB_RESP);
    assign ram_we   = wb_ack_o && we_q;
    assign ram_addr = (state_q == WB_IDLE) ? word_idx(wb_adr_i) : word_idx(adr_q);

    cellrv32_wb_resp_ram #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (ram_we),
        .byte_en (sel_q),
        .addr    (ram_addr),
        .wr_dat  (dat_q),
        .rd_en   (ram_re),
        .rd_dat  (ram_rdat)
    );

endmodule

// File: tb/tb_cellrv32_wb_responder.sv
// Testbench for cellrv32_wb_responder: three instances with different
// parameters (d0: 2 wait states classic, d1: 5 wait states classic with
// privileged-write filter, d2: 1 wait state pipelined), shared bus signals,
// one cyc per instance.
module tb_cellrv32_wb_responder;

    localparam logic [31:0] BASE = 32'h9000_0000;
    localparam int          MSZ  = 1024;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  tag;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic [2:0]  cyc;

    wire [31:0] rd0, rd1, rd2;
    wire        ack0, ack1, ack2;
    wire        err0, err1, err2;
    wire        busy0, busy1, busy2;

    always #5 clk = ~clk;

    cellrv32_wb_responder #(.MEM_SIZE(MSZ), .BASE_ADDR(BASE), .WAIT_STATES(2),
                            .PIPE_MODE(1'b0), .PRIV_WR_ONLY(1'b0)) u_d0 (
        .clk_i(clk), .rstn_i(rstn), .wb_tag_i(tag), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc[0]),
        .wb_dat_o(rd0), .wb_ack_o(ack0), .wb_err_o(err0), .busy_o(busy0));

    cellrv32_wb_responder #(.MEM_SIZE(MSZ), .BASE_ADDR(BASE), .WAIT_STATES(5),
                            .PIPE_MODE(1'b0), .PRIV_WR_ONLY(1'b1)) u_d1 (
        .clk_i(clk), .rstn_i(rstn), .wb_tag_i(tag), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc[1]),
        .wb_dat_o(rd1), .wb_ack_o(ack1), .wb_err_o(err1), .busy_o(busy1));

    cellrv32_wb_responder #(.MEM_SIZE(MSZ), .BASE_ADDR(BASE), .WAIT_STATES(1),
                            .PIPE_MODE(1'b1), .PRIV_WR_ONLY(1'b0)) u_d2 (
        .clk_i(clk), .rstn_i(rstn), .wb_tag_i(tag), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc[2]),
        .wb_dat_o(rd2), .wb_ack_o(ack2), .wb_err_o(err2), .busy_o(busy2));

    function automatic int wst(input int d);
        case (d)
            0:       return 2;
            1:       return 5;
            default: return 1;
        endcase
    endfunction

    function automatic bit is_pipe(input int d);
        return (d == 2);
    endfunction

    function automatic bit is_priv(input int d);
        return (d == 1);
    endfunction

    // {busy, ack, err, dat}
    function automatic logic [34:0] outs(input int d);
        case (d)
            0:       return {busy0, ack0, err0, rd0};
            1:       return {busy1, ack1, err1, rd1};
            default: return {busy2, ack2, err2, rd2};
        endcase
    endfunction

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference memory: plain word array per instance.
    logic [31:0] mdl [3][256];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // One complete access. Caller sits just after a falling edge.
    task automatic txn(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] dt, input logic [3:0] s, input logic [2:0] tg,
                       input logic eack, input logic eerr, input logic [31:0] edat,
                       input logic keep, input string nm);
        int          n;
        logic [34:0] o;
        bit          got;
        we = w; adr = a; wdat = dt; sel = s; tag = tg;
        stb = 1'b1; cyc[d] = 1'b1;
        n = 0; got = 0; o = '0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (is_pipe(d)) stb = 1'b0;
            o = outs(d);
            got = o[33] | o[32];
        end
        chk({nm, " latency"}, 64'(n), 64'(wst(d) + 1));
        chk({nm, " ack"}, 64'(o[33]), 64'(eack));
        chk({nm, " err"}, 64'(o[32]), 64'(eerr));
        chk({nm, " dat"}, 64'(o[31:0]), 64'(edat));
        @(negedge clk);
        o = outs(d);
        chk({nm, " pulse"}, 64'(o[33:32]), 64'd0);
        stb = 1'b0;
        cyc[d] = keep;
        if (!keep) @(negedge clk);
        if (eack && w) mdl[d][8'((a - BASE) >> 2)] = merge(mdl[d][8'((a - BASE) >> 2)], dt, s);
    endtask

    // Random access checked against the reference rules.
    task automatic rand_op(input int d, input logic keep, input string nm);
        logic        w, hit, rej, eack, eerr;
        logic [31:0] a, off, dt, edat;
        logic [3:0]  s;
        logic [2:0]  tg;
        int          k;
        w  = 1'($urandom_range(0, 1));
        k  = int'($urandom_range(0, 15));
        a  = BASE + 32'h200 + 32'(k * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0)
            a = ($urandom_range(0, 1) == 1) ? BASE + MSZ + 32'(k * 4) : BASE - 32'd4 - 32'(k * 4);
        dt = $urandom;
        s  = 4'($urandom_range(0, 15));
        tg = 3'($urandom_range(0, 7));
        off  = a - BASE;
        hit  = (a >= BASE) && (off < MSZ);
        rej  = is_priv(d) && w && !tg[0];
        eerr = !hit || rej;
        eack = !eerr;
        edat = (eack && !w) ? mdl[d][8'(off >> 2)] : 32'd0;
        txn(d, w, a, dt, s, tg, eack, eerr, edat, keep, nm);
    endtask

    typedef struct {
        int          d;
        logic        w;
        logic [31:0] off;
        logic [31:0] dt;
        logic [3:0]  s;
        logic [2:0]  tg;
        logic        ack;
        logic        err;
        logic [31:0] rdat;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [34:0] o;
        bit          bad;
        int          n;
        logic        keep;

        vt[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 3'b000, 1'b1, 1'b0, 32'h0};
        vt[1]  = '{0, 1'b0, 32'h10,  32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{0, 1'b1, 32'h10,  32'h000000AA, 4'h1, 3'b000, 1'b1, 1'b0, 32'h0};
        vt[3]  = '{0, 1'b0, 32'h10,  32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 32'hDEADBEAA};
        vt[4]  = '{0, 1'b0, 32'h13,  32'h0,        4'h0, 3'b000, 1'b1, 1'b0, 32'hDEADBEAA};
        vt[5]  = '{0, 1'b0, 32'h400, 32'h0,        4'hF, 3'b000, 1'b0, 1'b1, 32'h0};
        vt[6]  = '{0, 1'b1, 32'h10,  32'h11223344, 4'h0, 3'b000, 1'b1, 1'b0, 32'h0};
        vt[7]  = '{0, 1'b0, 32'h10,  32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 32'hDEADBEAA};
        vt[8]  = '{0, 1'b1, 32'h10,  32'h55667788, 4'hA, 3'b000, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{0, 1'b0, 32'h10,  32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 32'h55AD77AA};
        vt[10] = '{0, 1'b0, 32'hFFFFFFFC, 32'h0,   4'hF, 3'b000, 1'b0, 1'b1, 32'h0};
        vt[11] = '{0, 1'b1, 32'h410, 32'h0,        4'hF, 3'b000, 1'b0, 1'b1, 32'h0};
        vt[12] = '{0, 1'b0, 32'h10,  32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 32'h55AD77AA};
        vt[13] = '{1, 1'b1, 32'h20,  32'hCAFEF00D, 4'hF, 3'b000, 1'b0, 1'b1, 32'h0};
        vt[14] = '{1, 1'b1, 32'h20,  32'h12345678, 4'hF, 3'b001, 1'b1, 1'b0, 32'h0};
        vt[15] = '{1, 1'b0, 32'h20,  32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 32'h12345678};
        vt[16] = '{1, 1'b1, 32'h20,  32'hAAAAAAAA, 4'hF, 3'b110, 1'b0, 1'b1, 32'h0};
        vt[17] = '{1, 1'b0, 32'h20,  32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 32'h12345678};
        vt[18] = '{2, 1'b1, 32'h3FC, 32'hA5A50F0F, 4'hF, 3'b000, 1'b1, 1'b0, 32'h0};
        vt[19] = '{2, 1'b0, 32'h3FC, 32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 32'hA5A50F0F};
        vt[20] = '{2, 1'b0, 32'h3FC, 32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 32'hA5A50F0F};

        rstn = 1'b0; tag = '0; adr = '0; wdat = '0; we = 1'b0; sel = '0; stb = 1'b0; cyc = '0;
        #2;
        for (int d = 0; d < 3; d++) chk($sformatf("reset outs d%0d", d), 64'(outs(d)), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed table
        for (int i = 0; i < NV; i++) begin
            keep = (vt[i].d == 2) && (i + 1 < NV) && (vt[i + 1].d == 2);
            txn(vt[i].d, vt[i].w, BASE + vt[i].off, vt[i].dt, vt[i].s, vt[i].tg,
                vt[i].ack, vt[i].err, vt[i].rdat, keep, $sformatf("vec%0d", i));
        end

        // Abort in WAIT (5 wait states): no response, no write, next access normal
        we = 1'b1; adr = BASE + 32'h20; wdat = 32'hBADBAD00; sel = 4'hF; tag = 3'b001;
        stb = 1'b1; cyc[1] = 1'b1;
        @(negedge clk);
        chk("abort busy in wait", 64'(busy1), 64'd1);
        @(negedge clk);
        cyc[1] = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("abort busy after drop", 64'(busy1), 64'd0);
        bad = 0;
        repeat (8) begin
            if (ack1 || err1) bad = 1;
            @(negedge clk);
        end
        chk("abort no response", 64'(bad), 64'd0);
        txn(1, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 3'b000, 1'b1, 1'b0, 32'h12345678, 1'b0, "after abort");

        // Classic: stb held across the ack must not start a second access
        we = 1'b0; adr = BASE + 32'h10; sel = 4'hF; tag = 3'b000;
        stb = 1'b1; cyc[0] = 1'b1;
        n = 0; o = '0;
        while (!(o[33] | o[32]) && n < 20) begin
            @(negedge clk);
            n++;
            o = outs(0);
        end
        chk("hold latency", 64'(n), 64'd3);
        chk("hold dat", 64'(o[31:0]), 64'h55AD77AA);
        @(negedge clk);
        @(negedge clk);
        stb = 1'b0; cyc[0] = 1'b0;
        chk("hold no reaccept busy", 64'(busy0), 64'd0);
        bad = 0;
        repeat (6) begin
            if (ack0 || err0) bad = 1;
            @(negedge clk);
        end
        chk("hold no second response", 64'(bad), 64'd0);

        // Reset asserted in WAIT on the pipelined instance
        we = 1'b1; adr = BASE + 32'h3FC; wdat = 32'h0; sel = 4'hF; tag = 3'b001;
        stb = 1'b1; cyc[2] = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        chk("rst busy in wait", 64'(busy2), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst outs immediate", 64'(outs(2)), 64'd0);
        @(negedge clk);
        cyc[2] = 1'b0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        txn(2, 1'b0, BASE + 32'h3FC, 32'h0, 4'hF, 3'b000, 1'b1, 1'b0, 32'hA5A50F0F, 1'b0, "after reset");

        // Randomized accesses against the reference model
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 16; k++)
                txn(d, 1'b1, BASE + 32'h200 + 32'(k * 4), $urandom, 4'hF, 3'b001,
                    1'b1, 1'b0, 32'h0, 1'(is_pipe(d)), $sformatf("init d%0d w%0d", d, k));
            for (int i = 0; i < 40; i++)
                rand_op(d, 1'(is_pipe(d)), $sformatf("rand d%0d #%0d", d, i));
            cyc[d] = 1'b0;
            repeat (2) @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
